// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the CPU always wins, and one secondary master is served when the CPU is idle.
// Optional secondary write protection below PROT_BASE is enabled by defining DMEM_ARB_WPROT_EN.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 255,
  parameter logic [15:0] PROT_BASE  = 16'h0400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_daddr,
  input  logic        cpu_en,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  output logic        dma_ready,
  input  logic [15:0] dma_addr,
  input  logic        dma_wr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_wdone,
  output logic        dma_starved,
  output logic        dma_err,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StPend, StResp} state_e;

`ifdef DMEM_ARB_WPROT_EN
  localparam bit WprotEn = 1'b1;
`else
  localparam bit WprotEn = 1'b0;
`endif

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  state_e      state_q, state_d;
  logic [15:0] hold_addr_q, hold_addr_d;
  logic [15:0] hold_wdata_q, hold_wdata_d;
  logic        hold_wr_q, hold_wr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  starve_q, starve_d;
  logic        err_q, err_d;
  logic        blocked;

  // A protected write is retired without ever touching memory.
  assign blocked = WprotEn && hold_wr_q && (hold_addr_q < PROT_BASE);

  assign cpu_rdata   = mem_rdata;
  assign dma_rdata   = rdata_q;
  assign dma_starved = (starve_q == StarveMax);
  assign dma_err     = err_q;

  always_comb begin
    state_d      = state_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_wr_d    = hold_wr_q;
    rdata_d      = rdata_q;
    starve_d     = starve_q;
    err_d        = err_q;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    dma_ready    = 1'b0;
    dma_rvalid   = 1'b0;
    dma_wdone    = 1'b0;

    if (cpu_en) begin
      mem_en    = 1'b1;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_daddr;
      mem_wdata = cpu_wdata;
    end

    unique case (state_q)
      StIdle: begin
        dma_ready = 1'b1;
        if (dma_req) begin
          hold_addr_d  = dma_addr;
          hold_wdata_d = dma_wdata;
          hold_wr_d    = dma_wr;
          state_d      = StPend;
        end
      end
      StPend: begin
        if (blocked) begin
          err_d    = 1'b1;
          starve_d = 8'd0;
          state_d  = StResp;
        end else if (!cpu_en) begin
          mem_en    = 1'b1;
          mem_wr    = hold_wr_q;
          mem_addr  = hold_addr_q;
          mem_wdata = hold_wdata_q;
          if (!hold_wr_q) rdata_d = mem_rdata;
          starve_d  = 8'd0;
          state_d   = StResp;
        end else if (starve_q != StarveMax) begin
          starve_d = starve_q + 8'd1;
        end
      end
      StResp: begin
        dma_rvalid = !hold_wr_q;
        dma_wdone  = hold_wr_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      hold_addr_q  <= 16'h0000;
      hold_wdata_q <= 16'h0000;
      hold_wr_q    <= 1'b0;
      rdata_q      <= 16'h0000;
      starve_q     <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_wr_q    <= hold_wr_d;
      rdata_q      <= rdata_d;
      starve_q     <= starve_d;
      err_q        <= err_d;
    end
  end

endmodule
